// File: rtl/dep_sched_pkg.sv
// Shared types and default sizing for the dependency-aware task scheduler.
package dep_sched_pkg;

    localparam int N_TASKS_DEF     = 16;
    localparam int STALL_LIMIT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    typedef logic [$clog2(N_TASKS_DEF)-1:0] task_idx_t;
    typedef logic [N_TASKS_DEF-1:0]         task_vec_t;

endpackage

// File: rtl/dep_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    always_comb begin : pick
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/dep_scheduler.sv
// Dependency scheduler: grants each requesting task once per run, after any prerequisite completes.
// Optional stall detector enabled with `define DEP_SCHED_STALL_DETECT_EN.
module dep_scheduler
    import dep_sched_pkg::*;
#(
    parameter int N_TASKS     = N_TASKS_DEF,
    parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       cfg_we,
    input  logic [$clog2(N_TASKS)-1:0] cfg_idx,
    input  logic [N_TASKS-1:0]         cfg_mask,
    input  logic [N_TASKS-1:0]         req,
    output logic [N_TASKS-1:0]         gnt,
    output logic [N_TASKS-1:0]         done_vec,
    output logic                       all_done,
    output logic                       busy,
    output logic                       cfg_err
`ifdef DEP_SCHED_STALL_DETECT_EN
    ,output logic                      stall
`endif
);

    localparam int IDX_W = $clog2(N_TASKS);

    if (N_TASKS < 2 || N_TASKS > 512) begin : g_bad_n
        $error("dep_scheduler: N_TASKS out of range");
    end
    if (STALL_LIMIT < 2 || STALL_LIMIT > 65535) begin : g_bad_limit
        $error("dep_scheduler: STALL_LIMIT out of range");
    end

    state_t               state_q, state_d;
    logic [N_TASKS-1:0]   done_q, done_d;
    logic [N_TASKS-1:0]   gnt_q, gnt_d;
    logic [N_TASKS-1:0]   mask_q [N_TASKS];
    logic [N_TASKS-1:0]   mask_d [N_TASKS];
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 cfg_err_q, cfg_err_d;

    logic [N_TASKS-1:0]   elig;
    logic [N_TASKS-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_vld;
    logic                 cfg_ok;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_TASKS; i++) begin
            elig[i] = req[i] && !done_q[i] &&
                      ((mask_q[i] == '0) || ((mask_q[i] & done_q) != '0));
        end
    end

    rr_arbiter #(.N(N_TASKS), .IDX_W(IDX_W)) u_arb (
        .req     (elig),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Writes are rejected during a run, on self-dependency, or for a nonexistent task.
    assign cfg_ok = (state_q != RUN) && (32'(cfg_idx) < N_TASKS) && !cfg_mask[cfg_idx];

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        gnt_d     = '0;
        ptr_d     = ptr_q;
        cfg_err_d = 1'b0;
        mask_d    = mask_q;

        if (cfg_we) begin
            if (cfg_ok) mask_d[cfg_idx] = cfg_mask;
            else        cfg_err_d       = 1'b1;
        end

        case (state_q)
            IDLE, COMPLETE: begin
                if (start) begin
                    state_d = RUN;
                    done_d  = '0;
                    ptr_d   = '0;
                end
            end
            RUN: begin
                if (&done_q) begin
                    state_d = COMPLETE;
                end else if (arb_vld) begin
                    gnt_d  = arb_gnt;
                    done_d = done_q | arb_gnt;
                    ptr_d  = (32'(arb_idx) == N_TASKS - 1) ? '0 : arb_idx + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            done_q    <= '0;
            gnt_q     <= '0;
            ptr_q     <= '0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < N_TASKS; i++) mask_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            cfg_err_q <= cfg_err_d;
            mask_q    <= mask_d;
        end
    end

    assign gnt      = gnt_q;
    assign done_vec = done_q;
    assign all_done = (state_q == COMPLETE);
    assign busy     = (state_q == RUN);
    assign cfg_err  = cfg_err_q;

`ifdef DEP_SCHED_STALL_DETECT_EN
    localparam int CNT_W = $clog2(STALL_LIMIT + 1);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counts RUN cycles with outstanding work but nothing grantable; saturates at the limit.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q != RUN || state_d != RUN || arb_vld) begin
            stall_cnt_d = '0;
        end else if (((req & ~done_q) != '0) && (stall_cnt_q != CNT_W'(STALL_LIMIT))) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall = (stall_cnt_q == CNT_W'(STALL_LIMIT));
`endif

endmodule

// File: tb/tb_dep_scheduler.sv
// Directed bench for dep_scheduler (N_TASKS=16, STALL_LIMIT=8); stall checks need DEP_SCHED_STALL_DETECT_EN.
module tb_dep_scheduler;

    localparam int N = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          cfg_we;
    logic [3:0]    cfg_idx;
    logic [N-1:0]  cfg_mask;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done_vec;
    logic          all_done;
    logic          busy;
    logic          cfg_err;
`ifdef DEP_SCHED_STALL_DETECT_EN
    logic          stall;
`endif

    int checks   = 0;
    int failures = 0;

    dep_scheduler #(.N_TASKS(N), .STALL_LIMIT(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_mask (cfg_mask),
        .req      (req),
        .gnt      (gnt),
        .done_vec (done_vec),
        .all_done (all_done),
        .busy     (busy),
        .cfg_err  (cfg_err)
`ifdef DEP_SCHED_STALL_DETECT_EN
        ,.stall   (stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input int idx, input logic [N-1:0] m);
        cfg_we   = 1'b1;
        cfg_idx  = 4'(idx);
        cfg_mask = m;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int order [16] = '{0, 1, 2, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 3};
    int ngr;

    initial begin
        rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_mask = '0; req = '0;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_done", 32'(done_vec), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_all_done", 32'(all_done), 32'h0);
        check("rst_cfg_err", 32'(cfg_err), 32'h0);
        rst = 1'b0;

        // Round robin, no masks, req = 0x0005
        start = 1'b1; req = 16'h0005;
        tick();
        start = 1'b0;
        check("rr_busy", 32'(busy), 32'h1);
        check("rr_gnt0", 32'(gnt), 32'h0);
        tick();
        check("rr_gnt_t0", 32'(gnt), 32'h0001);
        tick();
        check("rr_gnt_t2", 32'(gnt), 32'h0004);
        check("rr_done", 32'(done_vec), 32'h0005);
        tick();
        check("rr_no_more", 32'(gnt), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_start_ignored", 32'(done_vec), 32'h0005);
        check("rr_still_busy", 32'(busy), 32'h1);

        // Write during RUN is dropped with a one-cycle error pulse
        cfg_write(4, 16'h0100);
        check("run_cfg_err", 32'(cfg_err), 32'h1);
        tick();
        check("run_cfg_err_drop", 32'(cfg_err), 32'h0);
        req = 16'h0010;
        tick();
        check("mask4_unchanged", 32'(gnt), 32'h0010);
        check("done_0x15", 32'(done_vec), 32'h0015);

        // Self-dependency rejected; legal write accepted
        do_reset();
        req = '0;
        cfg_write(7, 16'h0080);
        check("self_cfg_err", 32'(cfg_err), 32'h1);
        cfg_write(9, 16'h0400);
        check("good_cfg_no_err", 32'(cfg_err), 32'h0);
        start = 1'b1; req = 16'h0280;
        tick();
        start = 1'b0;
        tick();
        check("self_mask_dropped", 32'(gnt), 32'h0080);
        tick();
        check("mask9_blocks", 32'(gnt), 32'h0);
        req = 16'h02FF;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("fill_gnt", 32'(gnt), 32'h1 << i);
        end
        check("fill_done", 32'(done_vec), 32'h00FF);

        // Reset mid-run
        rst = 1'b1;
        tick();
        check("midrst_done", 32'(done_vec), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_gnt", 32'(gnt), 32'h0);
        rst = 1'b0;
        start = 1'b1; req = 16'h0200;
        tick();
        start = 1'b0;
        tick();
        check("midrst_masks_cleared", 32'(gnt), 32'h0200);

        // Dependency chain 1 -> 15 -> 3, last mask written together with start
        do_reset();
        cfg_write(3, 16'h8000);
        cfg_we = 1'b1; cfg_idx = 4'd15; cfg_mask = 16'h0002;
        start = 1'b1; req = 16'hFFFF;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        check("chain_busy", 32'(busy), 32'h1);
        check("chain_cfg_ok", 32'(cfg_err), 32'h0);
        ngr = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("chain_gnt", 32'(gnt), 32'h1 << order[i]);
            check("chain_not_done", 32'(all_done), 32'h0);
            if (gnt != '0) ngr++;
        end
        check("chain_grants", 32'(ngr), 32'd16);
        tick();
        check("chain_all_done", 32'(all_done), 32'h1);
        check("chain_busy_off", 32'(busy), 32'h0);
        check("chain_done_vec", 32'(done_vec), 32'hFFFF);
        tick();
        check("complete_hold", 32'(all_done), 32'h1);
        check("complete_gnt0", 32'(gnt), 32'h0);
        start = 1'b1; req = '0;
        tick();
        start = 1'b0;
        check("restart_clear", 32'(done_vec), 32'h0);
        check("restart_busy", 32'(busy), 32'h1);

`ifdef DEP_SCHED_STALL_DETECT_EN
        do_reset();
        cfg_write(5, 16'h0040);
        start = 1'b1; req = 16'h0020;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("stall_before", 32'(stall), 32'h0);
        tick();
        check("stall_rise", 32'(stall), 32'h1);
        tick();
        tick();
        check("stall_sat", 32'(stall), 32'h1);
        req = 16'h0060;
        tick();
        check("stall_gnt6", 32'(gnt), 32'h0040);
        check("stall_drop", 32'(stall), 32'h0);
        tick();
        check("stall_gnt5", 32'(gnt), 32'h0020);
        check("stall_low", 32'(stall), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
